// File: rtl/dmem_access_sequencer_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// The memory strobes are active-low, so "on" is a logic zero.
package dmem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } seq_state_e;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/dmem_access_sequencer_if.sv
// EX-stage request, data-memory and writeback response signals of the sequencer.
// slave is the sequencer's view; master is the surrounding pipeline and memory.
interface dmem_access_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              DmemREB;
    logic              DmemWEB;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              stall;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
        output DmemREB, DmemWEB, mem_addr, mem_wdata, stall, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata, mem_ready,
        input  DmemREB, DmemWEB, mem_addr, mem_wdata, stall, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_access_sequencer_timer.sv
// Wait-state counter: cleared when an access starts, counts stalled ACCESS cycles,
// and flags the last permitted cycle. It saturates there rather than wrapping.
import dmem_seq_pkg::*;

module dmem_wait_timer #(
    parameter  int TIMEOUT = TIMEOUT_DEFAULT,
    localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == LAST);

endmodule

// File: rtl/dmem_access_sequencer.sv
// Sequences one LW/SW at a time onto the data memory, stalling the pipeline
// until the memory is ready or the wait-state budget runs out.
import dmem_seq_pkg::*;

module dmem_access_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    dmem_access_sequencer_if.slave bus
);

    seq_state_e        r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_reb;
    logic              r_web;
    logic              r_rsp_valid;
    logic              r_rsp_err;
    logic [DATA_W-1:0] r_rsp_rdata;

    logic              w_accept;
    logic              w_count_en;
    logic              w_expired;

    assign w_accept   = (r_state == IDLE) && bus.req_valid;
    assign w_count_en = (r_state == ACCESS) && !bus.mem_ready;

    dmem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (CLK),
        .rst_n     (RSTN),
        .i_clear   (w_accept),
        .i_en      (w_count_en),
        .o_expired (w_expired)
    );

    // Strobes and the response pulse are registered on the state transitions
    // so they change only on clock edges and can never overlap.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_reb       <= STROBE_OFF;
            r_web       <= STROBE_OFF;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= 1'b0;
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_reb   <= bus.req_we ? STROBE_OFF : STROBE_ON;
                        r_web   <= bus.req_we ? STROBE_ON  : STROBE_OFF;
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Ready on the final count cycle takes priority over timeout.
                    if (bus.mem_ready) begin
                        if (!r_we) begin
                            r_rsp_rdata <= bus.mem_rdata;
                        end
                        r_rsp_err   <= 1'b0;
                        r_reb       <= STROBE_OFF;
                        r_web       <= STROBE_OFF;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end else if (w_expired) begin
                        if (!r_we) begin
                            r_rsp_rdata <= '0;
                        end
                        r_rsp_err   <= 1'b1;
                        r_reb       <= STROBE_OFF;
                        r_web       <= STROBE_OFF;
                        r_rsp_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_reb       <= STROBE_OFF;
                    r_web       <= STROBE_OFF;
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    // Stall rises in the request's own IDLE cycle so the EX registers hold it.
    assign bus.stall     = RSTN && ((r_state == ACCESS) || w_accept);
    assign bus.DmemREB   = r_reb;
    assign bus.DmemWEB   = r_web;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_dmem_access_sequencer.sv
// Directed bench for the data-memory access sequencer: a table of load/store
// transactions with hand-computed results, plus a reset-during-access sequence.
module tb_dmem_access_sequencer;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;
    localparam logic [31:0] GARBAGE = 32'hFFFF0000;

    logic CLK  = 1'b0;
    logic RSTN = 1'b1;

    int checks = 0;
    int errors = 0;

    dmem_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_access_sequencer #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        ready;
        int          waitN;
        logic [31:0] rdata;
        int          expCycles;
        logic [31:0] expRdata;
        logic        expErr;
        logic        holdValid;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // One full transaction: request cycle, ACCESS cycles, DONE, optional idle.
    task automatic applyStimulus(input vec_t v);
        @(posedge CLK); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = GARBAGE;
        @(negedge CLK);
        checkOutput("req_stall",     bus.stall,     1);
        checkOutput("req_reb",       bus.DmemREB,   1);
        checkOutput("req_web",       bus.DmemWEB,   1);
        checkOutput("req_rsp_valid", bus.rsp_valid, 0);
        for (int k = 0; k < v.expCycles; k++) begin
            @(posedge CLK); #1;
            bus.mem_ready = v.ready && (k == v.waitN);
            bus.mem_rdata = bus.mem_ready ? v.rdata : GARBAGE;
            @(negedge CLK);
            checkOutput("acc_reb",       bus.DmemREB,   v.we);
            checkOutput("acc_web",       bus.DmemWEB,   !v.we);
            checkOutput("acc_stall",     bus.stall,     1);
            checkOutput("acc_rsp_valid", bus.rsp_valid, 0);
            checkOutput("acc_mem_addr",  bus.mem_addr,  v.addr);
            checkOutput("acc_mem_wdata", bus.mem_wdata, v.wdata);
        end
        @(posedge CLK); #1;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = GARBAGE;
        @(negedge CLK);
        checkOutput("done_rsp_valid", bus.rsp_valid, 1);
        checkOutput("done_rsp_err",   bus.rsp_err,   v.expErr);
        checkOutput("done_rsp_rdata", bus.rsp_rdata, v.expRdata);
        checkOutput("done_stall",     bus.stall,     0);
        checkOutput("done_reb",       bus.DmemREB,   1);
        checkOutput("done_web",       bus.DmemWEB,   1);
        if (!v.holdValid) begin
            @(posedge CLK); #1;
            bus.req_valid = 1'b0;
            @(negedge CLK);
            checkOutput("idle_rsp_valid", bus.rsp_valid, 0);
            checkOutput("idle_reb",       bus.DmemREB,   1);
            checkOutput("idle_web",       bus.DmemWEB,   1);
            checkOutput("idle_stall",     bus.stall,     0);
            checkOutput("idle_rsp_rdata", bus.rsp_rdata, v.expRdata);
        end
    endtask

    initial begin
        vecs[0] = '{we:1'b0, addr:32'h10, wdata:32'h0,        ready:1'b1, waitN:0,  rdata:32'hDEADBEEF,
                    expCycles:1,  expRdata:32'hDEADBEEF, expErr:1'b0, holdValid:1'b0};
        vecs[1] = '{we:1'b1, addr:32'h20, wdata:32'h12345678, ready:1'b1, waitN:3,  rdata:32'hAAAA5555,
                    expCycles:4,  expRdata:32'hDEADBEEF, expErr:1'b0, holdValid:1'b0};
        vecs[2] = '{we:1'b0, addr:32'h30, wdata:32'h0,        ready:1'b0, waitN:0,  rdata:32'h0,
                    expCycles:15, expRdata:32'h0,        expErr:1'b1, holdValid:1'b0};
        vecs[3] = '{we:1'b0, addr:32'h40, wdata:32'h0,        ready:1'b1, waitN:14, rdata:32'hCAFEF00D,
                    expCycles:15, expRdata:32'hCAFEF00D, expErr:1'b0, holdValid:1'b0};
        vecs[4] = '{we:1'b1, addr:32'h50, wdata:32'h0BADC0DE, ready:1'b0, waitN:0,  rdata:32'h0,
                    expCycles:15, expRdata:32'hCAFEF00D, expErr:1'b1, holdValid:1'b0};
        vecs[5] = '{we:1'b0, addr:32'h60, wdata:32'h0,        ready:1'b1, waitN:1,  rdata:32'h13579BDF,
                    expCycles:2,  expRdata:32'h13579BDF, expErr:1'b0, holdValid:1'b1};
        vecs[6] = '{we:1'b1, addr:32'h64, wdata:32'h2468ACE0, ready:1'b1, waitN:0,  rdata:32'h55555555,
                    expCycles:1,  expRdata:32'h13579BDF, expErr:1'b0, holdValid:1'b0};

        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        #2 RSTN = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("rst_reb",       bus.DmemREB,   1);
        checkOutput("rst_web",       bus.DmemWEB,   1);
        checkOutput("rst_stall",     bus.stall,     0);
        checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("rst_rsp_err",   bus.rsp_err,   0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("rst_mem_addr",  bus.mem_addr,  0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
        @(posedge CLK); #1;
        RSTN = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of a load: everything drops at once, no response follows.
        @(posedge CLK); #1;
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h70;
        bus.mem_ready = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        checkOutput("mid_reb_active", bus.DmemREB, 0);
        #1 RSTN = 1'b0;
        #1;
        checkOutput("mid_rst_reb",       bus.DmemREB,   1);
        checkOutput("mid_rst_web",       bus.DmemWEB,   1);
        checkOutput("mid_rst_stall",     bus.stall,     0);
        checkOutput("mid_rst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("mid_rst_mem_addr",  bus.mem_addr,  0);
        checkOutput("mid_rst_rsp_rdata", bus.rsp_rdata, 0);
        bus.req_valid = 1'b0;
        @(posedge CLK); #1;
        RSTN = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checkOutput("post_rst_rsp_valid", bus.rsp_valid, 0);
            checkOutput("post_rst_reb",       bus.DmemREB,   1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_sequencer.md
Name: dmem_access_sequencer

Overview:
- Sequences data-memory accesses for LW/SW between the EX stage and the data memory.
- Accepts one load/store request at a time and drives the memory's active-low read/write enables for a variable number of wait-state cycles.
- Stalls the pipeline until the memory signals ready, or until a wait-state timeout expires.
- Returns load data and a one-cycle completion pulse to the writeback mux.

Parameters:
- ADDR_W, 32, width of the data-memory byte address.
- DATA_W, 32, width of the data word.
- TIMEOUT, 15, maximum number of ACCESS cycles allowed without mem_ready; must be >= 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- req_valid  in  1  load/store request present from the EX stage; held stable while stall=1.
- req_we  in  1  1 = store (SW), 0 = load (LW).
- req_addr  in  ADDR_W  access address (ALU result).
- req_wdata  in  DATA_W  store data.
- DmemREB  out  1  memory read enable, active-low.
- DmemWEB  out  1  memory write enable, active-low.
- mem_addr  out  ADDR_W  latched address to memory.
- mem_wdata  out  DATA_W  latched store data to memory.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  out  1  freeze upstream pipeline registers.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  load result, held until the next completion.
- rsp_err  out  1  timeout flag, valid with rsp_valid.

Behaviour:
- Reset (async, RSTN=0): state=IDLE; DmemREB=1; DmemWEB=1; stall=0; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_addr=0; mem_wdata=0; wait counter=0. Reset asserted mid-access aborts immediately and issues no response.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If req_valid=1, latch req_we/req_addr/req_wdata, clear the counter, and go to ACCESS.
  - stall = req_valid combinationally in IDLE, so the request is held from its first cycle.
- ACCESS:
  - Exactly one strobe is low: DmemREB=0 for a load, DmemWEB=0 for a store.
  - mem_addr and mem_wdata are stable for the whole state. stall=1.
  - If mem_ready=1: capture mem_rdata into rsp_rdata (loads only; stores leave rsp_rdata unchanged), set rsp_err=0, go to DONE.
  - Else if counter == TIMEOUT-1: set rsp_err=1, set rsp_rdata=0 for a load, go to DONE.
  - Else increment the counter.
  - mem_ready on the final count cycle wins over timeout.
- DONE:
  - Both strobes high; rsp_valid=1; stall=0; always return to IDLE next cycle.
  - req_valid seen in DONE is the request just completed; it is ignored. The pipeline advances on this edge.
- Latency: request in cycle 0, mem_ready in the first ACCESS cycle (cycle 1) gives rsp_valid in cycle 2. In general, rsp_valid follows the ready cycle by one cycle.
- Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, so at minimum one bubble cycle with both strobes high separates accesses.
- mem_ready outside ACCESS is ignored.
- DmemREB and DmemWEB are never low simultaneously. Both strobes are registered outputs, glitch-free.
- Counter width: clog2(TIMEOUT+1); it never wraps.

Decomposition:
- Shared package dmem_seq_pkg: state enum (IDLE, ACCESS, DONE), constants STROBE_ON=1'b0 and STROBE_OFF=1'b1, TIMEOUT default.
- One sub-module, dmem_wait_timer: loadable up-counter with clear, enable, and an expired output at TIMEOUT-1; parameterised by TIMEOUT.
- FSM, latches and strobe drive stay in the top.

Test Plan:
- Reset mid-ACCESS: assert RSTN=0 with DmemREB=0 -> DmemREB=1, stall=0, rsp_valid=0 within the same cycle (async); no rsp_valid after release.
- Load, zero wait: req_valid=1, req_we=0, addr=0x10, mem_ready=1 in the first ACCESS cycle with rdata=0xDEADBEEF -> DmemREB low for 1 cycle, rsp_valid in cycle 2, rsp_rdata=0xDEADBEEF, rsp_err=0, stall high in cycles 0-1.
- Store, 3 wait states: req_we=1, addr=0x20, wdata=0x12345678, mem_ready in the 4th ACCESS cycle -> DmemWEB low for 4 cycles, DmemREB stays 1, mem_wdata stable at 0x12345678, rsp_valid in cycle 5.
- Timeout: load with mem_ready held 0, TIMEOUT=15 -> DmemREB low for exactly 15 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0.
- Ready on the final count: mem_ready=1 in ACCESS cycle 15 (TIMEOUT=15) -> rsp_err=0, data captured.
- Back-to-back: load then store with req_valid held high continuously -> one IDLE bubble with both strobes high between the accesses; the req_valid seen in DONE does not start a duplicate access; never both strobes low.
